vga_timing_param: RTL

Parametrised VGA/VESA timing generator and the successor to the fixed 800x600@60 timing block. Horizontal and vertical geometry, sync polarity and counter widths are set by parameters. It also provides a data-enable output, line-start and frame-start strobes, and a frame counter. It sits at the head of the video pipeline, driven by the pixel clock, and feeds the draw/overlay stages and the VGA output pins.

---
 rtl/vga_timing_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA/VESA timing generator (counters, syncs,
// blanking, data enable, line/frame strobes and a completed-frame counter).
// Optional feature macro: VGA_TIMING_CE_EN adds the ce pixel clock enable port.
// Every output is registered and derived from the next counter values, so the
// flags always line up with hcount/vcount in the same cycle.
module vga_timing_param #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               pclk,
  input  logic               rst,
`ifdef VGA_TIMING_CE_EN
  input  logic               ce,
`endif
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(VS_END);

  // Elaboration guards: refuse illegal geometry instead of truncating counters.
  generate
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $fatal(1, "vga_timing_param: porch and sync widths must be >= 1");
    end
    if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
      $fatal(1, "vga_timing_param: CNT_W too small for H_TOTAL-1 or V_TOTAL-1");
    end
  endgenerate

  logic               adv;
  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic               de_q, de_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               hs_act, vs_act;

`ifdef VGA_TIMING_CE_EN
  assign adv = ce;
`else
  assign adv = 1'b1;
`endif

  // Next counter values, then every flag decoded from those next values.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    if (adv) begin
      if (hcount_q < H_LAST) begin
        hcount_d = hcount_q + CNT_W'(1);
      end else begin
        hcount_d = '0;
        if (vcount_q < V_LAST) begin
          vcount_d = vcount_q + CNT_W'(1);
        end else begin
          vcount_d = '0;
          frame_d  = frame_q + FRAME_W'(1);
        end
      end
    end
    hs_act        = (hcount_d >= HS_BEG_C) && (hcount_d < HS_END_C);
    vs_act        = (vcount_d >= VS_BEG_C) && (vcount_d < VS_END_C);
    hsync_d       = HS_POL ? hs_act : ~hs_act;
    vsync_d       = VS_POL ? vs_act : ~vs_act;
    hblnk_d       = (hcount_d >= H_ACT_C);
    vblnk_d       = (vcount_d >= V_ACT_C);
    de_d          = ~hblnk_d & ~vblnk_d;
    line_start_d  = (hcount_d == '0);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  // State and output registers; reset lands on the (0,0) pixel of a new frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_q       <= frame_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_cnt   = frame_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
